// File: rtl/data_mem_mc_if.sv
// rtl/data_mem_mc_if.sv - request/response bundle between a pipeline master and data_mem_mc
interface data_mem_mc_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              req;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output req, wr, addr, data_in,
      input  data_out, busy, done, err
   );

   modport slave (
      input  req, wr, addr, data_in,
      output data_out, busy, done, err
   );
endinterface

// File: rtl/data_mem_mc.sv
// rtl/data_mem_mc.sv - multi-cycle big-endian byte memory; DATA_MEM_ALIGN_CHECK_EN enables misalignment error
module data_mem_mc #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 4
) (
   input  logic         clk,
   input  logic         rst,
   data_mem_mc_if.slave bus
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_accept;
   logic               w_enter_done;

   logic               r_wr;
   logic [IDX_W-1:0]   r_idx;
   logic [DATA_W-1:0]  r_data;
   logic [DATA_W-1:0]  r_data_out;
   logic [7:0]         r_mem [DEPTH];

   logic               w_acc_wr;
   logic               w_acc_mis;
   logic               w_cap_mis;
   logic [IDX_W-1:0]   w_rd_base;
   logic [DATA_W-1:0]  w_rd_word;
   logic               w_unused;

   // upper address bits only matter for the alignment check; index wraps modulo DEPTH
   assign w_unused = ^bus.addr;

   // state and latency counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // next state: accept only in IDLE, count down WAIT, single-cycle DONE
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_accept     = 1'b0;
      w_enter_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.req) begin
               w_accept = 1'b1;
               if (LATENCY == 1) begin
                  w_state_nxt  = S_DONE;
                  w_enter_done = 1'b1;
                  w_cnt_nxt    = '0;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            // counter reaches zero on the same edge that enters DONE
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt  = S_DONE;
               w_enter_done = 1'b1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // capture operands at accept; they stay frozen until the access ends
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr   <= 1'b0;
         r_idx  <= '0;
         r_data <= '0;
      end else if (w_accept) begin
         r_wr   <= bus.wr;
         r_idx  <= bus.addr[IDX_W-1:0];
         r_data <= bus.data_in;
      end
   end

`ifdef DATA_MEM_ALIGN_CHECK_EN
   logic r_mis;
   logic w_in_mis;

   assign w_in_mis = (bus.addr % ADDR_W'(NB)) != '0;

   // remember whether the accepted address was not word aligned
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mis <= 1'b0;
      end else if (w_accept) begin
         r_mis <= w_in_mis;
      end
   end

   assign w_cap_mis = r_mis;
   assign w_acc_mis = (r_state == S_IDLE) ? w_in_mis : r_mis;
`else
   assign w_cap_mis = 1'b0;
   assign w_acc_mis = 1'b0;
`endif

   // with LATENCY=1 the DONE edge is also the accept edge, so use the live inputs then
   assign w_acc_wr  = (r_state == S_IDLE) ? bus.wr : r_wr;
   assign w_rd_base = (r_state == S_IDLE) ? bus.addr[IDX_W-1:0] : r_idx;

   // big-endian gather: lowest address lands in the most significant byte
   for (genvar g = 0; g < NB; g++) begin : g_rd
      assign w_rd_word[DATA_W-1-8*g -: 8] = r_mem[w_rd_base + IDX_W'(g)];
   end

   // read result loads on the edge entering DONE and holds until the next good read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data_out <= '0;
      end else if (w_enter_done && !w_acc_wr && !w_acc_mis) begin
         r_data_out <= w_rd_word;
      end
   end

   // write all bytes on the edge leaving DONE; reset forces IDLE so an aborted write never lands
   always_ff @(posedge clk) begin
      if (r_state == S_DONE && r_wr && !w_cap_mis) begin
         for (int k = 0; k < NB; k++) begin
            r_mem[r_idx + IDX_W'(k)] <= r_data[DATA_W-1-8*k -: 8];
         end
      end
   end

   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = (r_state == S_DONE);
   assign bus.err      = (r_state == S_DONE) && w_cap_mis;
   assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_data_mem_mc.sv
// tb/tb_data_mem_mc.sv - directed self-checking bench for data_mem_mc (LATENCY 4 and 1 instances)
module tb_data_mem_mc;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   data_mem_mc_if #(.DATA_W(16), .ADDR_W(16)) b4 ();
   data_mem_mc_if #(.DATA_W(16), .ADDR_W(16)) b1 ();

   data_mem_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH(64), .LATENCY(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (b4.slave)
   );

   data_mem_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH(64), .LATENCY(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input bit l1, input logic q, input logic w, input logic [15:0] a, input logic [15:0] d);
      if (l1) begin
         b1.req = q; b1.wr = w; b1.addr = a; b1.data_in = d;
      end else begin
         b4.req = q; b4.wr = w; b4.addr = a; b4.data_in = d;
      end
   endtask

   // one complete access; returns latency in cycles, busy-high cycles and err at done
   task automatic access(input bit l1, input logic w, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output int nbusy, output logic e);
      logic dn;
      @(negedge clk);
      drive(l1, 1'b1, w, a, d);
      lat = 0; nbusy = 0; dn = 1'b0; e = 1'b0;
      while (!dn && lat < 20) begin
         @(negedge clk);
         if (lat == 0) drive(l1, 1'b0, ~w, ~a, ~d);
         lat++;
         dn = l1 ? b1.done : b4.done;
         e  = l1 ? b1.err : b4.err;
         if (l1 ? b1.busy : b4.busy) nbusy++;
      end
      n_checks++;
      if (!dn) begin n_fail++; $display("FAIL access_timeout addr=%h got no done required done", a); end
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++; if (b4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b required 0", b4.busy); end
      n_checks++; if (b4.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b required 0", b4.done); end
      n_checks++; if (b4.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b required 0", b4.err); end
      n_checks++; if (b4.data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data_out got %h required 0000", b4.data_out); end
      n_checks++; if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin n_fail++; $display("FAIL reset_l1 got busy=%b done=%b required 0 0", b1.busy, b1.done); end
      rst = 1'b1;
   endtask

   task automatic test_write_read();
      int lat, nb; logic e;
      access(0, 1, 16'h0010, 16'hBEEF, lat, nb, e);
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL wr_latency got %0d required 4", lat); end
      n_checks++; if (nb != 4) begin n_fail++; $display("FAIL wr_busy_cycles got %0d required 4", nb); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b required 0", e); end
      n_checks++; if (b4.data_out !== 16'h0000) begin n_fail++; $display("FAIL wr_keeps_data_out got %h required 0000", b4.data_out); end
      access(0, 0, 16'h0010, 16'h0000, lat, nb, e);
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL rd_latency got %0d required 4", lat); end
      n_checks++; if (b4.data_out !== 16'hBEEF) begin n_fail++; $display("FAIL rd_0010 got %h required BEEF", b4.data_out); end
      access(0, 0, 16'h0050, 16'h0000, lat, nb, e);
      n_checks++; if (b4.data_out !== 16'hBEEF) begin n_fail++; $display("FAIL rd_mod_depth got %h required BEEF", b4.data_out); end
      access(0, 1, 16'h0012, 16'hCAFE, lat, nb, e);
      n_checks++; if (b4.data_out !== 16'hBEEF) begin n_fail++; $display("FAIL wr2_keeps_data_out got %h required BEEF", b4.data_out); end
      access(0, 0, 16'h0011, 16'h0000, lat, nb, e);
`ifdef DATA_MEM_ALIGN_CHECK_EN
      n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL rd_0011_err got %b required 1", e); end
      n_checks++; if (b4.data_out !== 16'hBEEF) begin n_fail++; $display("FAIL rd_0011_unchanged got %h required BEEF", b4.data_out); end
`else
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL rd_0011_err got %b required 0", e); end
      n_checks++; if (b4.data_out !== 16'hEFCA) begin n_fail++; $display("FAIL rd_0011_order got %h required EFCA", b4.data_out); end
`endif
   endtask

   task automatic test_wrap();
      int lat, nb; logic e;
      access(0, 1, 16'h0000, 16'h5566, lat, nb, e);
      access(0, 1, 16'h003E, 16'h7788, lat, nb, e);
      access(0, 1, 16'h003F, 16'h1234, lat, nb, e);
      access(0, 0, 16'h0000, 16'h0000, lat, nb, e);
      n_checks++; if (b4.data_out !== 16'h3466) begin n_fail++; $display("FAIL wrap_byte0 got %h required 3466", b4.data_out); end
      access(0, 0, 16'h003E, 16'h0000, lat, nb, e);
      n_checks++; if (b4.data_out !== 16'h7712) begin n_fail++; $display("FAIL wrap_byte63 got %h required 7712", b4.data_out); end
   endtask

   task automatic test_back_to_back();
      int ndone = 0; int nbusy = 0; int first = -1; int last = -1; int gap_bad = 0;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (b4.done) begin
            ndone++;
            if (last >= 0 && (i - last) != 5) gap_bad++;
            if (first < 0) first = i;
            last = i;
         end
         if (b4.busy) nbusy++;
      end
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      n_checks++; if (ndone != 4) begin n_fail++; $display("FAIL b2b_done_count got %0d required 4", ndone); end
      n_checks++; if (first != 4) begin n_fail++; $display("FAIL b2b_first_done got %0d required 4", first); end
      n_checks++; if (gap_bad != 0) begin n_fail++; $display("FAIL b2b_spacing got %0d bad gaps required 0", gap_bad); end
      n_checks++; if (nbusy != 16) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d required 16", nbusy); end
      n_checks++; if (b4.data_out !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_data got %h required BEEF", b4.data_out); end
   endtask

   task automatic test_busy_ignore();
      int lat, nb; logic e; int ndone = 0;
      access(0, 1, 16'h0022, 16'h2222, lat, nb, e);
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 16'h0020, 16'h1111);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (b4.done) ndone++;
         if (i == 1 || i == 2) drive(0, 1'b1, 1'b1, 16'h0022, 16'h9999);
         else drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      end
      n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d required 1", ndone); end
      access(0, 0, 16'h0020, 16'h0000, lat, nb, e);
      n_checks++; if (b4.data_out !== 16'h1111) begin n_fail++; $display("FAIL ignore_captured got %h required 1111", b4.data_out); end
      access(0, 0, 16'h0022, 16'h0000, lat, nb, e);
      n_checks++; if (b4.data_out !== 16'h2222) begin n_fail++; $display("FAIL ignore_not_queued got %h required 2222", b4.data_out); end
   endtask

   task automatic test_reset_abort();
      int lat, nb; logic e; int ndone = 0;
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 16'h0020, 16'h5A5A);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      n_checks++; if (b4.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %b required 1", b4.busy); end
      #2 rst = 1'b0;
      #1;
      n_checks++; if (b4.busy !== 1'b0 || b4.done !== 1'b0 || b4.err !== 1'b0) begin
         n_fail++; $display("FAIL abort_ctrl got busy=%b done=%b err=%b required 0 0 0", b4.busy, b4.done, b4.err); end
      n_checks++; if (b4.data_out !== 16'h0000) begin n_fail++; $display("FAIL abort_data_out got %h required 0000", b4.data_out); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (b4.done) ndone++;
      end
      n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done got %0d required 0", ndone); end
      access(0, 0, 16'h0020, 16'h0000, lat, nb, e);
      n_checks++; if (b4.data_out !== 16'h1111) begin n_fail++; $display("FAIL abort_no_write got %h required 1111", b4.data_out); end
   endtask

   task automatic test_latency1();
      int lat, nb; logic e;
      access(1, 1, 16'h0008, 16'h4321, lat, nb, e);
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL l1_wr_latency got %0d required 1", lat); end
      access(1, 0, 16'h0008, 16'h0000, lat, nb, e);
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL l1_rd_latency got %0d required 1", lat); end
      n_checks++; if (nb != 1) begin n_fail++; $display("FAIL l1_busy_cycles got %0d required 1", nb); end
      n_checks++; if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL l1_idle_after got %b required 0", b1.busy); end
      n_checks++; if (b1.data_out !== 16'h4321) begin n_fail++; $display("FAIL l1_rd_data got %h required 4321", b1.data_out); end
   endtask

`ifdef DATA_MEM_ALIGN_CHECK_EN
   task automatic test_align();
      int lat, nb; logic e;
      access(0, 1, 16'h0004, 16'h0102, lat, nb, e);
      access(0, 1, 16'h0006, 16'h0304, lat, nb, e);
      access(0, 0, 16'h0004, 16'h0000, lat, nb, e);
      access(0, 1, 16'h0005, 16'hAAAA, lat, nb, e);
      n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL align_err got %b required 1", e); end
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL align_latency got %0d required 4", lat); end
      n_checks++; if (b4.err !== 1'b0) begin n_fail++; $display("FAIL align_err_idle got %b required 0", b4.err); end
      access(0, 0, 16'h0004, 16'h0000, lat, nb, e);
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL align_next_err got %b required 0", e); end
      n_checks++; if (b4.data_out !== 16'h0102) begin n_fail++; $display("FAIL align_0004 got %h required 0102", b4.data_out); end
      access(0, 0, 16'h0006, 16'h0000, lat, nb, e);
      n_checks++; if (b4.data_out !== 16'h0304) begin n_fail++; $display("FAIL align_0006 got %h required 0304", b4.data_out); end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      test_reset();
      test_write_read();
`ifndef DATA_MEM_ALIGN_CHECK_EN
      test_wrap();
`endif
      test_back_to_back();
      test_busy_ignore();
      test_reset_abort();
      test_latency1();
`ifdef DATA_MEM_ALIGN_CHECK_EN
      test_align();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
